hc595_scan_ctrl: RTL and testbench
==================================

Name: hc595_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display behind the dual-74HC595 serial driver. It holds a double-buffered 8-digit hex frame and steps a one-hot digit select at a fixed refresh rate. It decodes the active digit to segment code and presents sel[7:0] and seg[7:0] to the shift-register driver. New frames are accepted through a valid/ready handshake and committed only at frame boundaries, so a partial update is never displayed.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
SCAN_FREQ, 1_000, per-digit dwell rate in Hz; dwell = CLOCK_FREQ/SCAN_FREQ clocks
MCNT_SCAN, CLOCK_FREQ/SCAN_FREQ-1, derived terminal count of the dwell counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
disp_data  input  32  8 hex nibbles; digit i = disp_data[4i+3:4i]
disp_dp  input  8  decimal point per digit, 1 = lit
disp_en  input  8  digit enable, 0 = blank digit
load_valid  input  1  staging request for disp_data/disp_dp/disp_en
load_ready  output  1  staging buffer empty; transfer occurs when valid && ready
display_on  input  1  global enable; 0 forces outputs dark
sel  output  8  one-hot digit select, active-high, to serial driver
seg  output  8  segment code, active-low; seg[7] = dp, seg[6:0] = g..a
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low. All state is reset asynchronously.
- Reset values:
  - sel = 8'h00, seg = 8'hFF, frame_done = 0, load_ready = 1.
  - Dwell counter = 0, digit index = 0.
  - Active and staging registers cleared: en = 0, so the display is blank until the first commit.
- Dwell counter:
  - Counts 0..MCNT_SCAN and wraps to 0.
  - tick = (counter == MCNT_SCAN).
  - On tick, the 3-bit digit index increments, wrapping 7 -> 0.
- Staging FSM:
  - States: EMPTY and PEND. load_ready = (state == EMPTY), driven directly from the state register.
  - EMPTY with load_valid = 1: capture all three inputs into staging, go to PEND.
  - PEND with tick and index == 7 (frame boundary): copy staging to active, go to EMPTY, pulse frame_done for that cycle.
  - In PEND, load_valid is ignored; inputs are not captured.
- Frame boundary: occurs every 8*(MCNT_SCAN+1) clocks whether or not a commit happens; frame_done pulses at every boundary.
- Commit timing: the committed frame is first shown on digit 0 in the cycle after the boundary. A load therefore waits at most one frame plus one clock.
- Outputs: sel and seg are registered from the index and active data, so they change exactly one clock after the index changes.
  - sel = 1 << index when display_on = 1, else 8'h00.
  - seg[6:0] = decode(nibble[index]) if en[index] = 1, else 7'h7F.
  - seg[7] = ~(dp[index] & en[index]).
  - When display_on = 0: seg = 8'hFF.
- Blanked digits: the digit still receives its sel slot, with seg dark, so dwell timing stays uniform.
- Decode table (active-low, {g..a}, 0..F): C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E, low 7 bits used.
- display_on: affects outputs only. The dwell counter, index, FSM and frame_done keep running.
- Reset mid-operation: all outputs and state return to reset values immediately. A pending staged frame is discarded.

Test Plan:
- Bench parameters: CLOCK_FREQ=1000, SCAN_FREQ=100, so the dwell is 10 clocks and a frame is 80 clocks.
1. Reset behaviour: hold reset_n = 0 -> sel = 00, seg = FF, load_ready = 1. Release with no load -> sel steps 01, 02, .. 80 every 10 clocks with seg = FF throughout.
2. Basic load: load 32'h76543210, en = FF, dp = 00 -> load_ready drops the next cycle; frame_done pulses at the boundary. Then sel = 01/seg = C0, sel = 08/seg = B0, sel = 80/seg = F8, each held 10 clocks.
3. Back-to-back loads: hold load_valid with A = 32'h11111111 then B = 32'h22222222 -> B is captured only after A commits. B is displayed (seg = A4) exactly one frame after A (seg = F9).
4. Enable and decimal point: data = 32'hFFFFFFFA, en = 0F, dp = 01, display_on = 1 ->
   - digit0 seg = 08;
   - digits 1-3 seg = 8E;
   - digits 4-7 keep their sel slot with seg = FF.
5. Global blank: drop display_on mid-digit -> the next clock gives sel = 00, seg = FF. frame_done keeps pulsing every 80 clocks. Restoring display_on resumes at the current index with no phase slip.
6. Reset during PEND: assert reset_n = 0 while PEND, 3 clocks before the boundary -> outputs reset immediately. After release, the staged data is never displayed and seg stays FF.

Source files
------------

// File: rtl/hc595_scan_ctrl.sv
// rtl/hc595_scan_ctrl.sv - 8-digit seven-segment scan controller with double-buffered frame
//
// Steps a one-hot digit select at a fixed dwell rate and presents the decoded
// segment pattern of the active digit to the dual-74HC595 serial driver.
// New frames are staged through a valid/ready handshake and committed only at
// frame boundaries (end of digit 7 dwell), so a partial frame is never shown.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   disp_data    8 hex nibbles, digit i = disp_data[4i+3:4i]
//   disp_dp      decimal point per digit, 1 = lit
//   disp_en      digit enable, 0 = blank digit
//   load_valid   staging request for disp_data/disp_dp/disp_en
//   load_ready   staging buffer empty; transfer when load_valid && load_ready
//   display_on   global enable, 0 forces outputs dark
//   sel          one-hot digit select, active-high
//   seg          segment code, active-low, seg[7] = dp, seg[6:0] = g..a
//   frame_done   one-cycle pulse at each frame boundary
module hc595_scan_ctrl #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int SCAN_FREQ  = 1_000,
    parameter int MCNT_SCAN  = CLOCK_FREQ / SCAN_FREQ - 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] disp_data,
    input  logic [7:0]  disp_dp,
    input  logic [7:0]  disp_en,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        display_on,
    output logic [7:0]  sel,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int CW = (MCNT_SCAN > 0) ? $clog2(MCNT_SCAN + 1) : 1;
    localparam logic [CW-1:0] MCNT_W = CW'(MCNT_SCAN);

    typedef enum logic {
        EMPTY = 1'b0,
        PEND  = 1'b1
    } stage_state_t;

    stage_state_t state_q;
    stage_state_t state_d;

    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic          tick;
    logic          boundary;
    logic          capture;
    logic          commit;

    logic [31:0]   stg_data;
    logic [7:0]    stg_dp;
    logic [7:0]    stg_en;
    logic [31:0]   act_data;
    logic [7:0]    act_dp;
    logic [7:0]    act_en;

    logic [3:0]    cur_nibble;
    logic          cur_en;
    logic          cur_dp;

    // Active-low {g..a} pattern for one hex nibble.
    function automatic logic [6:0] decode_hex(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick     = (cnt_q == MCNT_W);
    assign boundary = tick && (idx_q == 3'd7);

    // Dwell counter and digit index keep running regardless of display_on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
        end else if (tick) begin
            cnt_q <= '0;
            idx_q <= idx_q + 3'd1;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        commit     = 1'b0;
        frame_done = boundary;
        case (state_q)
            EMPTY: begin
                if (load_valid) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    commit  = 1'b1;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign load_ready = (state_q == EMPTY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_data <= '0;
            stg_dp   <= '0;
            stg_en   <= '0;
        end else if (capture) begin
            stg_data <= disp_data;
            stg_dp   <= disp_dp;
            stg_en   <= disp_en;
        end
    end

    // The index wraps to 0 on the same edge as the commit, so the new frame
    // starts cleanly on digit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_data <= '0;
            act_dp   <= '0;
            act_en   <= '0;
        end else if (commit) begin
            act_data <= stg_data;
            act_dp   <= stg_dp;
            act_en   <= stg_en;
        end
    end

    assign cur_nibble = act_data[{idx_q, 2'b00} +: 4];
    assign cur_en     = act_en[idx_q];
    assign cur_dp     = act_dp[idx_q];

    // Blanked digits still get their sel slot so every digit dwells equally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel <= 8'h00;
            seg <= 8'hFF;
        end else if (display_on) begin
            sel <= 8'h01 << idx_q;
            seg <= {~(cur_dp & cur_en), cur_en ? decode_hex(cur_nibble) : 7'h7F};
        end else begin
            sel <= 8'h00;
            seg <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// tb/tb_hc595_scan_ctrl.sv - directed self-checking bench for hc595_scan_ctrl
module tb_hc595_scan_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] disp_data;
    logic [7:0]  disp_dp;
    logic [7:0]  disp_en;
    logic        load_valid;
    logic        load_ready;
    logic        display_on;
    logic [7:0]  sel;
    logic [7:0]  seg;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;

    hc595_scan_ctrl #(
        .CLOCK_FREQ(1000),
        .SCAN_FREQ (100)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .disp_data  (disp_data),
        .disp_dp    (disp_dp),
        .disp_en    (disp_en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .display_on (display_on),
        .sel        (sel),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Advance to #1 after edge number 'target' counted from reset release.
    task automatic go_to(input int target);
        while (t < target) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] s_exp, input logic [7:0] g_exp);
        check({tag, "_sel"}, {24'h0, sel}, {24'h0, s_exp});
        check({tag, "_seg"}, {24'h0, seg}, {24'h0, g_exp});
    endtask

    initial begin
        reset_n    = 1'b0;
        disp_data  = 32'h0;
        disp_dp    = 8'h00;
        disp_en    = 8'h00;
        load_valid = 1'b0;
        display_on = 1'b1;

        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        chk_out("rst", 8'h00, 8'hFF);
        check("rst_ready", {31'h0, load_ready}, 32'h1);
        check("rst_fd", {31'h0, frame_done}, 32'h0);
        reset_n = 1'b1;
        t = 0;
        for (int i = 0; i < 8; i++) begin
            go_to(1 + 10 * i);
            chk_out($sformatf("idle_d%0d", i), 8'h01 << i, 8'hFF);
        end
        go_to(78);
        check("fd_pre", {31'h0, frame_done}, 32'h0);
        go_to(79);
        check("fd_b1", {31'h0, frame_done}, 32'h1);

        // 2. basic load
        go_to(80);
        check("fd_post", {31'h0, frame_done}, 32'h0);
        disp_data  = 32'h76543210;
        disp_en    = 8'hFF;
        disp_dp    = 8'h00;
        load_valid = 1'b1;
        go_to(81);
        load_valid = 1'b0;
        check("ld_ready_drop", {31'h0, load_ready}, 32'h0);
        go_to(159);
        check("ld_fd", {31'h0, frame_done}, 32'h1);
        chk_out("ld_precommit", 8'h80, 8'hFF);
        go_to(160);
        check("ld_ready_back", {31'h0, load_ready}, 32'h1);
        go_to(161);
        chk_out("ld_d0", 8'h01, 8'hC0);
        go_to(170);
        chk_out("ld_d0_hold", 8'h01, 8'hC0);
        go_to(191);
        chk_out("ld_d3", 8'h08, 8'hB0);
        go_to(200);
        chk_out("ld_d3_hold", 8'h08, 8'hB0);
        go_to(231);
        chk_out("ld_d7", 8'h80, 8'hF8);

        // 3. back-to-back loads
        go_to(240);
        disp_data  = 32'h11111111;
        load_valid = 1'b1;
        go_to(241);
        check("b2b_a_taken", {31'h0, load_ready}, 32'h0);
        disp_data = 32'h22222222;
        go_to(319);
        check("b2b_still_pend", {31'h0, load_ready}, 32'h0);
        go_to(320);
        check("b2b_ready_gap", {31'h0, load_ready}, 32'h1);
        go_to(321);
        load_valid = 1'b0;
        check("b2b_b_taken", {31'h0, load_ready}, 32'h0);
        chk_out("b2b_a_d0", 8'h01, 8'hF9);
        go_to(391);
        chk_out("b2b_a_d7", 8'h80, 8'hF9);
        go_to(401);
        chk_out("b2b_b_d0", 8'h01, 8'hA4);

        // 4. enables and decimal point
        disp_data  = 32'hFFFFFFFA;
        disp_en    = 8'h0F;
        disp_dp    = 8'h01;
        load_valid = 1'b1;
        go_to(402);
        load_valid = 1'b0;
        go_to(481);
        chk_out("en_d0", 8'h01, 8'h08);
        go_to(491);
        chk_out("en_d1", 8'h02, 8'h8E);
        go_to(511);
        chk_out("en_d3", 8'h08, 8'h8E);
        go_to(521);
        chk_out("en_d4", 8'h10, 8'hFF);
        go_to(551);
        chk_out("en_d7", 8'h80, 8'hFF);

        // 5. global blank
        go_to(565);
        display_on = 1'b0;
        go_to(566);
        chk_out("off", 8'h00, 8'hFF);
        go_to(638);
        check("off_fd_pre", {31'h0, frame_done}, 32'h0);
        go_to(639);
        check("off_fd", {31'h0, frame_done}, 32'h1);
        go_to(645);
        display_on = 1'b1;
        go_to(646);
        chk_out("on_d0", 8'h01, 8'h08);
        go_to(651);
        chk_out("on_d1", 8'h02, 8'h8E);

        // 6. reset while PEND
        disp_data  = 32'h88888888;
        disp_en    = 8'hFF;
        disp_dp    = 8'hFF;
        load_valid = 1'b1;
        go_to(652);
        load_valid = 1'b0;
        check("r6_pend", {31'h0, load_ready}, 32'h0);
        go_to(716);
        reset_n = 1'b0;
        #1;
        chk_out("r6_async", 8'h00, 8'hFF);
        check("r6_ready", {31'h0, load_ready}, 32'h1);
        check("r6_fd", {31'h0, frame_done}, 32'h0);
        go_to(718);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            go_to(719 + 10 * i);
            chk_out($sformatf("r6_d%0d", i), 8'h01 << i, 8'hFF);
        end
        go_to(718 + 161);
        chk_out("r6_next", 8'h01, 8'hFF);
        check("r6_ready_end", {31'h0, load_ready}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
